dbus_sram_ctrl: RTL and testbench

Responder end of the CPU data bus (dbus). Accepts single-word read/write requests from naive_mips on the dbus, converts them to timed cycles on an external 32-bit asynchronous SRAM built from two 16-bit parts, and holds the CPU via dbus_stall until each access completes. Replaces the zero-latency behavioural RAM in board-level builds and simulation.

---
 rtl/dbus_sram_ctrl.sv | 101 ++++++++++
 tb/tb_dbus_sram_ctrl.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/dbus_sram_ctrl.sv
// Data-bus responder that turns single-word dbus requests into timed cycles on a
// 32-bit asynchronous SRAM, stalling the CPU until each access completes.
module dbus_sram_ctrl #(
  parameter int unsigned ADDR_WIDTH = 20,
  parameter int unsigned RD_WAIT    = 2,
  parameter int unsigned WR_WAIT    = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [31:0]           dbus_address,
  input  logic [3:0]            dbus_byteenable,
  input  logic                  dbus_read,
  input  logic                  dbus_write,
  input  logic [31:0]           dbus_wrdata,
  output logic [31:0]           dbus_rddata,
  output logic                  dbus_stall,
  output logic [ADDR_WIDTH-3:0] sram_addr,
  output logic [31:0]           sram_data_o,
  output logic                  sram_data_oe,
  input  logic [31:0]           sram_data_i,
  output logic                  sram_ce_n,
  output logic                  sram_oe_n,
  output logic                  sram_we_n,
  output logic [3:0]            sram_be_n
);

  localparam logic [3:0] RdCnt = 4'(RD_WAIT - 1);
  localparam logic [3:0] WrCnt = 4'(WR_WAIT - 1);

  typedef enum logic [1:0] {StIdle, StAccess, StDone} state_e;

  state_e     state_q;
  logic [3:0] cnt_q;
  logic       is_write_q;
  logic       req;
  logic       unused_addr;

  assign req = dbus_read | dbus_write;

  // Address bits outside the decoded word range alias onto the same word.
  assign unused_addr = ^{dbus_address[31:ADDR_WIDTH], dbus_address[1:0]};

  assign dbus_stall = rst_n & req & (state_q != StDone);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= StIdle;
      cnt_q        <= 4'd0;
      is_write_q   <= 1'b0;
      dbus_rddata  <= 32'h0;
      sram_addr    <= '0;
      sram_data_o  <= 32'h0;
      sram_data_oe <= 1'b0;
      sram_ce_n    <= 1'b1;
      sram_oe_n    <= 1'b1;
      sram_we_n    <= 1'b1;
      sram_be_n    <= 4'hF;
    end else begin
      case (state_q)
        StIdle: begin
          if (req) begin
            // A simultaneous read and write is resolved as a write.
            is_write_q   <= dbus_write;
            sram_addr    <= dbus_address[ADDR_WIDTH-1:2];
            sram_data_o  <= dbus_wrdata;
            sram_be_n    <= ~dbus_byteenable;
            sram_ce_n    <= 1'b0;
            sram_oe_n    <= dbus_write;
            sram_we_n    <= ~dbus_write;
            sram_data_oe <= dbus_write;
            cnt_q        <= dbus_write ? WrCnt : RdCnt;
            state_q      <= StAccess;
          end
        end
        StAccess: begin
          if (cnt_q == 4'd0) begin
            if (!is_write_q) begin
              dbus_rddata <= sram_data_i;
            end
            // Address, data and pad drive stay put through DONE for hold time.
            sram_ce_n <= 1'b1;
            sram_oe_n <= 1'b1;
            sram_we_n <= 1'b1;
            sram_be_n <= 4'hF;
            state_q   <= StDone;
          end else begin
            cnt_q <= cnt_q - 4'd1;
          end
        end
        StDone: begin
          sram_data_oe <= 1'b0;
          state_q      <= StIdle;
        end
        default: begin
          state_q <= StIdle;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_dbus_sram_ctrl.sv
// Directed bench for dbus_sram_ctrl: default-wait instance plus a
// RD_WAIT=1 / WR_WAIT=5 instance, each against a behavioural 32-bit SRAM.
module tb_dbus_sram_ctrl;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic [31:0] d_addr  [2];
  logic [3:0]  d_be    [2];
  logic        d_rd    [2];
  logic        d_wr    [2];
  logic [31:0] d_wdata [2];
  logic [31:0] d_rdata [2];
  logic        d_stall [2];
  logic [17:0] s_addr  [2];
  logic [31:0] s_do    [2];
  logic        s_doe   [2];
  logic [31:0] s_di    [2];
  logic        ce_n    [2];
  logic        oe_n    [2];
  logic        we_n    [2];
  logic [3:0]  be_n    [2];

  logic [31:0] mem [2][1024];
  logic        bd_en;
  int          bd_sel;
  logic [9:0]  bd_addr;
  logic [31:0] bd_data;

  int errors = 0;
  int checks = 0;

  dbus_sram_ctrl #(.ADDR_WIDTH(20), .RD_WAIT(2), .WR_WAIT(2)) u_dut0 (
    .clk(clk), .rst_n(rst_n),
    .dbus_address(d_addr[0]), .dbus_byteenable(d_be[0]), .dbus_read(d_rd[0]),
    .dbus_write(d_wr[0]), .dbus_wrdata(d_wdata[0]), .dbus_rddata(d_rdata[0]),
    .dbus_stall(d_stall[0]), .sram_addr(s_addr[0]), .sram_data_o(s_do[0]),
    .sram_data_oe(s_doe[0]), .sram_data_i(s_di[0]), .sram_ce_n(ce_n[0]),
    .sram_oe_n(oe_n[0]), .sram_we_n(we_n[0]), .sram_be_n(be_n[0])
  );

  dbus_sram_ctrl #(.ADDR_WIDTH(20), .RD_WAIT(1), .WR_WAIT(5)) u_dut1 (
    .clk(clk), .rst_n(rst_n),
    .dbus_address(d_addr[1]), .dbus_byteenable(d_be[1]), .dbus_read(d_rd[1]),
    .dbus_write(d_wr[1]), .dbus_wrdata(d_wdata[1]), .dbus_rddata(d_rdata[1]),
    .dbus_stall(d_stall[1]), .sram_addr(s_addr[1]), .sram_data_o(s_do[1]),
    .sram_data_oe(s_doe[1]), .sram_data_i(s_di[1]), .sram_ce_n(ce_n[1]),
    .sram_oe_n(oe_n[1]), .sram_we_n(we_n[1]), .sram_be_n(be_n[1])
  );

  // Behavioural SRAM: lane writes while ce/we low and pads driven; async read.
  always @(posedge clk) begin
    if (bd_en) mem[bd_sel][bd_addr] <= bd_data;
    for (int k = 0; k < 2; k++) begin
      if (!ce_n[k] && !we_n[k] && s_doe[k]) begin
        for (int b = 0; b < 4; b++) begin
          if (!be_n[k][b]) mem[k][s_addr[k][9:0]][8*b +: 8] <= s_do[k][8*b +: 8];
        end
      end
    end
  end

  always_comb begin
    for (int k = 0; k < 2; k++) begin
      s_di[k] = (!ce_n[k] && !oe_n[k]) ? mem[k][s_addr[k][9:0]] : 32'h0;
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic preload(input int sel, input logic [9:0] a, input logic [31:0] v);
    bd_en = 1'b1; bd_sel = sel; bd_addr = a; bd_data = v;
    @(posedge clk); #1;
    bd_en = 1'b0;
  endtask

  // Called at a negedge; returns at the first negedge where stall is low.
  task automatic wait_done(input int sel, output int stl, output int oe_c, output int we_c,
                           output logic [3:0] be_seen);
    stl = 0; oe_c = 0; we_c = 0; be_seen = 4'hF;
    while (d_stall[sel]) begin
      if (!oe_n[sel]) oe_c++;
      if (!we_n[sel]) we_c++;
      if (!ce_n[sel]) be_seen = be_n[sel];
      stl++;
      if (stl > 40) begin
        check("stall_timeout", 32'(stl), 32'd0);
        break;
      end
      @(negedge clk);
    end
  endtask

  task automatic access(input int sel, input logic wr, input logic rd, input logic [31:0] a,
                        input logic [3:0] be, input logic [31:0] wd,
                        output int stl, output int oe_c, output int we_c,
                        output logic [3:0] be_seen, output logic [31:0] rdata,
                        output logic [17:0] addr_done);
    d_wr[sel] = wr; d_rd[sel] = rd; d_addr[sel] = a; d_be[sel] = be; d_wdata[sel] = wd;
    @(negedge clk);
    wait_done(sel, stl, oe_c, we_c, be_seen);
    rdata = d_rdata[sel];
    addr_done = s_addr[sel];
    @(posedge clk); #1;
    d_wr[sel] = 1'b0; d_rd[sel] = 1'b0;
  endtask

  int          stl, oe_c, we_c;
  logic [3:0]  be_seen;
  logic [31:0] rdata;
  logic [17:0] adone;
  time         t0;

  initial begin
    rst_n = 1'b0; bd_en = 1'b0; bd_sel = 0; bd_addr = '0; bd_data = '0;
    for (int k = 0; k < 2; k++) begin
      d_addr[k] = '0; d_be[k] = 4'hF; d_rd[k] = 1'b0; d_wr[k] = 1'b0; d_wdata[k] = '0;
    end
    d_rd[0] = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_stall", 32'(d_stall[0]), 32'd0);
    check("rst_rddata", d_rdata[0], 32'h0);
    check("rst_addr", 32'(s_addr[0]), 32'h0);
    check("rst_data_o", s_do[0], 32'h0);
    check("rst_strobes", {27'd0, s_doe[0], ce_n[0], oe_n[0], we_n[0], 1'b0},
          {27'd0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0});
    check("rst_be_n", 32'(be_n[0]), 32'hF);
    d_rd[0] = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    preload(0, 10'h040, 32'hDEADBEEF);
    preload(0, 10'h041, 32'h11223344);
    preload(1, 10'h040, 32'hCAFEF00D);

    // Plain read
    access(0, 1'b0, 1'b1, 32'h80000100, 4'hF, 32'h0, stl, oe_c, we_c, be_seen, rdata, adone);
    check("rd_stall", 32'(stl), 32'd3);
    check("rd_oe_cycles", 32'(oe_c), 32'd2);
    check("rd_data", rdata, 32'hDEADBEEF);
    check("rd_addr", 32'(adone), 32'h40);

    // Byte-lane write, then readback
    access(0, 1'b1, 1'b0, 32'h104, 4'b0010, 32'h0000AB00, stl, oe_c, we_c, be_seen, rdata, adone);
    check("bw_stall", 32'(stl), 32'd3);
    check("bw_we_cycles", 32'(we_c), 32'd2);
    check("bw_be_n", 32'(be_seen), 32'hD);
    check("bw_rddata_kept", rdata, 32'hDEADBEEF);
    access(0, 1'b0, 1'b1, 32'h104, 4'hF, 32'h0, stl, oe_c, we_c, be_seen, rdata, adone);
    check("bw_readback", rdata, 32'h1122AB44);

    // Back-to-back write then read
    t0 = $time;
    access(0, 1'b1, 1'b0, 32'h200, 4'hF, 32'h55AA55AA, stl, oe_c, we_c, be_seen, rdata, adone);
    check("b2b_wr_stall", 32'(stl), 32'd3);
    access(0, 1'b0, 1'b1, 32'h200, 4'hF, 32'h0, stl, oe_c, we_c, be_seen, rdata, adone);
    check("b2b_rd_stall", 32'(stl), 32'd3);
    check("b2b_data", rdata, 32'h55AA55AA);
    check("b2b_cycles", 32'(($time - t0) / 10), 32'd8);

    // Simultaneous read+write behaves as a write
    access(0, 1'b1, 1'b1, 32'h300, 4'hF, 32'h12345678, stl, oe_c, we_c, be_seen, rdata, adone);
    check("rw_stall", 32'(stl), 32'd3);
    check("rw_we_cycles", 32'(we_c), 32'd2);
    check("rw_oe_cycles", 32'(oe_c), 32'd0);
    check("rw_rddata_kept", rdata, 32'h55AA55AA);
    access(0, 1'b0, 1'b1, 32'h300, 4'hF, 32'h0, stl, oe_c, we_c, be_seen, rdata, adone);
    check("rw_readback", rdata, 32'h12345678);

    // Read flushed after one cycle still completes and updates rddata
    d_rd[0] = 1'b1; d_addr[0] = 32'h200;
    @(posedge clk); #1;
    d_rd[0] = 1'b0;
    repeat (4) @(posedge clk);
    @(negedge clk);
    check("flush_stall", 32'(d_stall[0]), 32'd0);
    check("flush_rddata", d_rdata[0], 32'h55AA55AA);

    // Reset during the second ACCESS cycle of a write, request held
    d_wr[0] = 1'b1; d_addr[0] = 32'h104; d_be[0] = 4'hF; d_wdata[0] = 32'hFFFFFFFF;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst_n = 1'b0;
    @(negedge clk);
    check("mr_stall_in_rst", 32'(d_stall[0]), 32'd0);
    @(negedge clk);
    check("mr_strobes", {28'd0, ce_n[0], we_n[0], s_doe[0], d_stall[0]},
          {28'd0, 1'b1, 1'b1, 1'b0, 1'b0});
    check("mr_be_n", 32'(be_n[0]), 32'hF);
    check("mr_rddata", d_rdata[0], 32'h0);
    rst_n = 1'b1;
    #1;
    wait_done(0, stl, oe_c, we_c, be_seen);
    check("mr_restart_stall", 32'(stl), 32'd3);
    check("mr_restart_we", 32'(we_c), 32'd2);
    @(posedge clk); #1;
    d_wr[0] = 1'b0;
    access(0, 1'b0, 1'b1, 32'h104, 4'hF, 32'h0, stl, oe_c, we_c, be_seen, rdata, adone);
    check("mr_readback", rdata, 32'hFFFFFFFF);

    // RD_WAIT=1 / WR_WAIT=5 instance, including address aliasing
    access(1, 1'b0, 1'b1, 32'h00000100, 4'hF, 32'h0, stl, oe_c, we_c, be_seen, rdata, adone);
    check("p_rd_stall", 32'(stl), 32'd2);
    check("p_rd_oe_cycles", 32'(oe_c), 32'd1);
    check("p_rd_data", rdata, 32'hCAFEF00D);
    access(1, 1'b1, 1'b0, 32'h00000100, 4'hF, 32'hA5A5A5A5, stl, oe_c, we_c, be_seen, rdata,
           adone);
    check("p_wr_stall", 32'(stl), 32'd6);
    check("p_wr_we_cycles", 32'(we_c), 32'd5);
    access(1, 1'b0, 1'b1, 32'h00100100, 4'hF, 32'h0, stl, oe_c, we_c, be_seen, rdata, adone);
    check("p_alias_data", rdata, 32'hA5A5A5A5);
    check("p_alias_addr", 32'(adone), 32'h40);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
